button_event_arbiter: RTL
=========================

Name: button_event_arbiter

Overview:
- Collects conditioned button activity (cond/rising/falling) from N input conditioners.
- Generates press, release, long-press and auto-repeat events per button.
- Serialises the events onto one valid/ready event stream with round-robin arbitration.
- Sits between the per-button input conditioners and the downstream command/register logic.

Parameters:
N, 4, number of buttons (2..8)
IDXW, 2, width of button index (ceil(log2 N))
HOLD_CYCLES, 16, consecutive cond-high cycles before a long event (>=2)
REPEAT_CYCLES, 8, cycles between repeat events after long (>=2)

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
cond  input  N  conditioned level per button
rising  input  N  1-cycle rising pulse per button
falling  input  N  1-cycle falling pulse per button
ev_valid  output  1  event available
ev_ready  input  1  consumer accepts event (transfer when ev_valid & ev_ready at posedge)
ev_btn  output  IDXW  button index of current event
ev_type  output  2  00 press, 01 release, 10 long, 11 repeat
ovf  output  N  sticky per-button overwrite flag
clr_ovf  input  1  clears all ovf bits

Behaviour:
- Reset (clk edge with reset=1): slots empty, hold counters and phases 0, ev_valid=0, ev_btn=0, ev_type=00, ovf=0, rr pointer=0. Pending and in-flight events are discarded. Hold timing restarts from the first cycle after reset even if cond is already high.
- Per-button one-entry slot (full flag + 2-bit type). Event sources, one edge per cycle:
  - rising[i] gives press.
  - falling[i] gives release.
  - Hold timer gives long or repeat.
  - Priority if several occur in the same cycle: release > press > long/repeat. Lower-priority events that cycle are dropped and set ovf[i].
- Hold timer per button:
  - Counter clears whenever cond[i]=0; otherwise it increments.
  - Long is generated in the cycle where cond[i] has been high for HOLD_CYCLES consecutive cycles, counting the first high cycle as 1.
  - After long, a repeat is generated every REPEAT_CYCLES cycles while cond stays high.
  - cond low returns the button to the pre-long phase.
  - Counters saturate or reload; they never wrap into a spurious long.
- Slot write:
  - An event arriving while the slot is full (and not being granted that edge) overwrites the type and sets ovf[i].
  - If the slot is granted on the same edge, the new event is stored and ovf is not set.
- ovf: set as above and held. clr_ovf=1 clears all bits; a set in the same cycle wins over the clear.
- Output register:
  - Loads when empty (ev_valid=0) or on transfer (ev_valid & ev_ready).
  - On load, grant the first full slot searching from rr pointer upward, mod N. Set ev_valid=1 with ev_btn/ev_type, clear that slot, and set rr = granted+1 mod N.
  - If no slot is full at load time, ev_valid=0 and ev_btn/ev_type hold their last value.
  - Back-to-back transfers sustain one event per cycle.
- Handshake: while ev_valid=1 & ev_ready=0, ev_valid, ev_btn and ev_type are held stable. ev_valid never deasserts without a transfer (except on reset).
- Latency, with the output register empty:
  - Pulse at cycle t is stored in the slot at the end of t.
  - ev_valid=1 from cycle t+1 (one-cycle event-to-valid latency, no bypass).
- ev_ready with ev_valid=0 has no effect.

Test Plan:
- Reset, then rising[2] pulse at cycle 5 with ev_ready=1 -> ev_valid=1 at cycle 6, ev_btn=2, ev_type=00, for one cycle only; ovf=0.
- Same-cycle rising on buttons 0,1,3 from rr=0, ev_ready=1 -> three consecutive valid cycles with ev_btn 0,1,3; then press on 0 and 3 together -> 0 granted first (rr=0 after wrap from 3).
- cond[1] high from cycle 0 (rising at 0), HOLD=16, REPEAT=8, ev_ready=1 -> press stored at 0, long at 15, repeats at 23 and 31; each appears on ev_valid one cycle later. cond low at cycle 34 with falling -> release, no further repeats.
- ev_ready=0 stall: press on button 0, then rising and falling on button 0 in later cycles -> output holds press, ev_btn=0, stable; slot overwritten to release, ovf[0]=1; ev_ready=1 -> press then release delivered; clr_ovf clears ovf[0].
- Simultaneous rising[3] and falling[3] in one cycle -> single release event, ovf[3]=1.
- Reset asserted while ev_valid=1 and two slots full, with cond[2] held high -> ev_valid=0 next cycle, no stale events; long for button 2 appears exactly HOLD_CYCLES cycles after reset deasserts.

Source files
------------

// File: rtl/button_event_arbiter_if.sv
// Event-stream bundle between the button conditioners, the arbiter and the consumer.
// The master side is the arbiter; the slave side drives the buttons and accepts events.
interface button_event_arbiter_if #(
    parameter int N    = 4,
    parameter int IDXW = 2
);
    logic [N-1:0]    cond;
    logic [N-1:0]    rising;
    logic [N-1:0]    falling;
    logic            ev_valid;
    logic            ev_ready;
    logic [IDXW-1:0] ev_btn;
    logic [1:0]      ev_type;
    logic [N-1:0]    ovf;
    logic            clr_ovf;

    modport master (
        input  cond, rising, falling, ev_ready, clr_ovf,
        output ev_valid, ev_btn, ev_type, ovf
    );

    modport slave (
        output cond, rising, falling, ev_ready, clr_ovf,
        input  ev_valid, ev_btn, ev_type, ovf
    );
endinterface

// File: rtl/button_event_arbiter.sv
// Turns per-button edge/level activity into press/release/long/repeat events and
// serialises them onto one valid/ready stream with round-robin arbitration.
module button_event_arbiter #(
    parameter int N             = 4,
    parameter int IDXW          = 2,
    parameter int HOLD_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8
) (
    input logic                    clk,
    input logic                    reset,
    button_event_arbiter_if.master bus
);
    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_RELEASE = 2'b01;
    localparam logic [1:0] EV_LONG    = 2'b10;
    localparam logic [1:0] EV_REPEAT  = 2'b11;

    typedef enum logic {
        PH_PRE_LONG,
        PH_REPEAT
    } phase_t;

    logic [CW-1:0]   hold_cnt [N];
    phase_t          phase [N];
    logic [N-1:0]    slot_full_p0;
    logic [1:0]      slot_type_p0 [N];
    logic [IDXW-1:0] rr;

    logic [CW-1:0]   hold_cnt_nxt [N];
    phase_t          phase_nxt [N];
    logic [N-1:0]    hold_ev;
    logic [1:0]      hold_type [N];
    logic [N-1:0]    ev_new;
    logic [1:0]      ev_new_type [N];
    logic [N-1:0]    ovf_set;
    logic            load;
    logic            found;
    logic [IDXW-1:0] scan_idx;
    logic [IDXW-1:0] gnt_idx;
    logic [IDXW-1:0] rr_nxt;
    logic [N-1:0]    gnt_vec;

    // Stage p0 (combinational): hold timers. Counters reload to zero on every
    // emitted event, so they stay below CNT_MAX and can never wrap.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            hold_ev[i]      = 1'b0;
            hold_type[i]    = EV_LONG;
            hold_cnt_nxt[i] = hold_cnt[i] + CW'(1);
            phase_nxt[i]    = phase[i];
            if (!bus.cond[i]) begin
                hold_cnt_nxt[i] = '0;
                phase_nxt[i]    = PH_PRE_LONG;
            end else if (phase[i] == PH_PRE_LONG) begin
                if (hold_cnt[i] == CW'(HOLD_CYCLES - 1)) begin
                    hold_ev[i]      = 1'b1;
                    hold_cnt_nxt[i] = '0;
                    phase_nxt[i]    = PH_REPEAT;
                end
            end else if (hold_cnt[i] == CW'(REPEAT_CYCLES - 1)) begin
                hold_ev[i]      = 1'b1;
                hold_type[i]    = EV_REPEAT;
                hold_cnt_nxt[i] = '0;
            end
        end
    end

    // Round-robin scan over the slots as they stand before this edge's writes.
    always_comb begin
        load     = !bus.ev_valid || bus.ev_ready;
        found    = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = IDXW'((int'(rr) + k) % N);
            if (!found && slot_full_p0[scan_idx]) begin
                found   = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        gnt_vec = '0;
        if (load && found) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
        rr_nxt = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IDXW'(1);
    end

    // Source priority release > press > hold; anything lost or overwritten flags ovf.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            ev_new[i] = bus.falling[i] | bus.rising[i] | hold_ev[i];
            if (bus.falling[i]) begin
                ev_new_type[i] = EV_RELEASE;
            end else if (bus.rising[i]) begin
                ev_new_type[i] = EV_PRESS;
            end else begin
                ev_new_type[i] = hold_type[i];
            end
            ovf_set[i] = (bus.falling[i] & bus.rising[i])
                       | (bus.falling[i] & hold_ev[i])
                       | (bus.rising[i]  & hold_ev[i])
                       | (ev_new[i] & slot_full_p0[i] & ~gnt_vec[i]);
        end
    end

    // Stage p0 -> p1 register boundary: timers, slots, output register, ovf.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                hold_cnt[i] <= '0;
                phase[i]    <= PH_PRE_LONG;
            end
            slot_full_p0 <= '0;
            rr           <= '0;
            bus.ev_valid <= 1'b0;
            bus.ev_btn   <= '0;
            bus.ev_type  <= EV_PRESS;
            bus.ovf      <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                hold_cnt[i] <= hold_cnt_nxt[i];
                phase[i]    <= phase_nxt[i];
                if (ev_new[i]) begin
                    slot_full_p0[i] <= 1'b1;
                    slot_type_p0[i] <= ev_new_type[i];
                end else if (gnt_vec[i]) begin
                    slot_full_p0[i] <= 1'b0;
                end
            end
            if (load) begin
                bus.ev_valid <= found;
                if (found) begin
                    bus.ev_btn  <= gnt_idx;
                    bus.ev_type <= slot_type_p0[gnt_idx];
                    rr          <= rr_nxt;
                end
            end
            bus.ovf <= (bus.ovf & ~{N{bus.clr_ovf}}) | ovf_set;
        end
    end
endmodule
